// File: rtl/sync_pulse_arbiter.sv
// Round-robin arbiter that funnels per-requester event pulses into one shared pulse synchronizer.
// Grant-to-pulse is 1 cycle (2 from req_pulse); a new transfer waits for synchro_busy to rise and fall.
module sync_pulse_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 3,
  parameter int ACK_TIMEOUT = 8,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic               clk_fast,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic [NUM_REQ-1:0] ovf_clr,
  input  logic               synchro_busy,
  output logic               sync_pulse,
  output logic [IDW-1:0]     sync_id,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overflow,
  output logic               timeout_err,
  output logic               arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       ACK_LIM = 8'(ACK_TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     sync_id_q, sync_id_d;
  logic [7:0]         ack_cnt_q, ack_cnt_d;
  logic [NUM_REQ-1:0] overflow_q, overflow_d;
  logic               sync_pulse_q, sync_pulse_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pend;
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic               grant_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = (cnt_q[i] != '0);
    end
  end

  // First pending requester after the last winner, wrapping around.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_vld && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && gnt_vld && !synchro_busy;

  always_comb begin
    logic               dec;
    logic [NUM_REQ-1:0] ovf_set;
    dec     = 1'b0;
    ovf_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec      = grant_fire && (gnt_idx == IDW'(i));
      cnt_d[i] = cnt_q[i];
      if (req_pulse[i] && !dec) begin
        if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (!req_pulse[i] && dec) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    // A fresh drop wins over a clear arriving on the same cycle.
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
  end

  always_comb begin
    state_d      = state_q;
    sync_pulse_d = 1'b0;
    sync_id_d    = sync_id_q;
    last_d       = last_q;
    ack_cnt_d    = ack_cnt_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (grant_fire) begin
          state_d      = ISSUE;
          sync_pulse_d = 1'b1;
          sync_id_d    = gnt_idx;
          last_d       = gnt_idx;
        end
      end
      ISSUE: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (synchro_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q + 8'd1 == ACK_LIM) begin
          // Lost handshake: the event is dropped rather than retried.
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!synchro_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= IDW'(NUM_REQ - 1);
      sync_id_q    <= '0;
      ack_cnt_q    <= '0;
      overflow_q   <= '0;
      sync_pulse_q <= 1'b0;
      timeout_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sync_id_q    <= sync_id_d;
      ack_cnt_q    <= ack_cnt_d;
      overflow_q   <= overflow_d;
      sync_pulse_q <= sync_pulse_d;
      timeout_q    <= timeout_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sync_pulse  = sync_pulse_q;
  assign sync_id     = sync_id_q;
  assign pending     = pend;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// Directed bench for sync_pulse_arbiter: cycle vector table plus multi-cycle corner sequences.
module tb_sync_pulse_arbiter;

  logic       clk_fast = 1'b0;
  logic       reset_n;
  logic [3:0] req_pulse;
  logic [3:0] ovf_clr;
  logic       synchro_busy;
  logic       sync_pulse;
  logic [1:0] sync_id;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       timeout_err;
  logic       arb_busy;

  logic man_busy;
  logic model_en;
  logic model_busy;
  int   dly;
  int   bcnt;
  int   pulse_cnt;
  int   ids [256];
  int   total;
  int   bad;

  assign synchro_busy = model_en ? model_busy : man_busy;

  sync_pulse_arbiter #(.NUM_REQ(4), .CNT_W(3), .ACK_TIMEOUT(8)) dut (
    .clk_fast    (clk_fast),
    .reset_n     (reset_n),
    .req_pulse   (req_pulse),
    .ovf_clr     (ovf_clr),
    .synchro_busy(synchro_busy),
    .sync_pulse  (sync_pulse),
    .sync_id     (sync_id),
    .pending     (pending),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .arb_busy    (arb_busy)
  );

  always #5 clk_fast = ~clk_fast;

  // Synchronizer model: busy rises 2 cycles after a pulse and stays high 6 cycles.
  initial begin
    model_busy = 1'b0;
    dly        = 0;
    bcnt       = 0;
    forever begin
      @(posedge clk_fast);
      #2;
      if (!model_en) begin
        model_busy = 1'b0;
        dly        = 0;
        bcnt       = 0;
      end else begin
        if (bcnt > 0) begin
          bcnt = bcnt - 1;
          if (bcnt == 0) model_busy = 1'b0;
        end else if (dly > 0) begin
          dly = dly - 1;
          if (dly == 0) begin
            model_busy = 1'b1;
            bcnt       = 6;
          end
        end
        if (sync_pulse) dly = 2;
      end
    end
  end

  initial begin
    pulse_cnt = 0;
    forever begin
      @(posedge clk_fast);
      #1;
      if (sync_pulse && pulse_cnt < 256) begin
        ids[pulse_cnt] = int'(sync_id);
        pulse_cnt      = pulse_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic       busy;
    logic [3:0] pend;
    logic       sp;
    logic [1:0] id;
    logic       ab;
  } vec_t;

  vec_t vt [30];

  function automatic vec_t mk(input logic [3:0] req, input logic busy, input logic [3:0] pend,
                              input logic sp, input logic [1:0] id, input logic ab);
    vec_t v;
    v.req = req; v.busy = busy; v.pend = pend; v.sp = sp; v.id = id; v.ab = ab;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_fast);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_pulse = '0;
    ovf_clr   = '0;
    man_busy  = 1'b0;
    model_en  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int n_exp, input int base);
    int c;
    c = 0;
    while (!((pulse_cnt - base) >= n_exp && !arb_busy && pending == 4'd0) && c < 300) begin
      tick();
      c = c + 1;
    end
    chk({name, "_drain_in_time"}, 32'(c < 300), 32'd1);
  endtask

  initial begin
    int base;
    int c;
    logic prev_b;
    logic seen;
    total = 0;
    bad   = 0;

    // cycle vectors: inputs applied before an edge, outputs expected after it
    vt[0]  = mk(4'b0001, 0, 4'b0001, 0, 2'd0, 0);
    vt[1]  = mk(4'b0000, 0, 4'b0000, 1, 2'd0, 1);
    vt[2]  = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 1);
    vt[3]  = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 1);
    vt[4]  = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 1);
    vt[5]  = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 0);
    vt[6]  = mk(4'b0101, 0, 4'b0101, 0, 2'd0, 0);
    vt[7]  = mk(4'b0000, 0, 4'b0001, 1, 2'd2, 1);
    vt[8]  = mk(4'b0000, 1, 4'b0001, 0, 2'd2, 1);
    vt[9]  = mk(4'b0000, 1, 4'b0001, 0, 2'd2, 1);
    vt[10] = mk(4'b0000, 0, 4'b0001, 0, 2'd2, 0);
    vt[11] = mk(4'b0000, 0, 4'b0000, 1, 2'd0, 1);
    vt[12] = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 1);
    vt[13] = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 1);
    vt[14] = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 0);
    vt[15] = mk(4'b0001, 0, 4'b0001, 0, 2'd0, 0);
    vt[16] = mk(4'b0001, 0, 4'b0001, 1, 2'd0, 1);
    vt[17] = mk(4'b0000, 0, 4'b0001, 0, 2'd0, 1);
    vt[18] = mk(4'b0000, 1, 4'b0001, 0, 2'd0, 1);
    vt[19] = mk(4'b1000, 1, 4'b1001, 0, 2'd0, 1);
    vt[20] = mk(4'b0000, 0, 4'b1001, 0, 2'd0, 0);
    vt[21] = mk(4'b0000, 1, 4'b1001, 0, 2'd0, 0);
    vt[22] = mk(4'b0000, 0, 4'b0001, 1, 2'd3, 1);
    vt[23] = mk(4'b0000, 0, 4'b0001, 0, 2'd3, 1);
    vt[24] = mk(4'b0000, 1, 4'b0001, 0, 2'd3, 1);
    vt[25] = mk(4'b0000, 0, 4'b0001, 0, 2'd3, 0);
    vt[26] = mk(4'b0000, 0, 4'b0000, 1, 2'd0, 1);
    vt[27] = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 1);
    vt[28] = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 1);
    vt[29] = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 0);

    do_reset();
    chk("reset_outputs", 32'({sync_pulse, sync_id, pending, overflow, timeout_err, arb_busy}), 32'd0);

    for (int i = 0; i < 30; i++) begin
      req_pulse = vt[i].req;
      man_busy  = vt[i].busy;
      tick();
      chk($sformatf("vec%0d", i),
          32'({pending, sync_pulse, sync_id, arb_busy, overflow, timeout_err}),
          32'({vt[i].pend, vt[i].sp, vt[i].id, vt[i].ab, 4'b0000, 1'b0}));
    end
    req_pulse = '0;
    man_busy  = 1'b0;

    // single event through the synchronizer model
    do_reset();
    model_en  = 1'b1;
    base      = pulse_cnt;
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    chk("single_pending", 32'(pending), 32'h1);
    chk("single_no_early_pulse", 32'(sync_pulse), 32'd0);
    tick();
    chk("single_pulse_lat2", 32'({sync_pulse, sync_id}), 32'({1'b1, 2'd0}));
    prev_b = 1'b0;
    seen   = 1'b0;
    c      = 0;
    while (!seen && c < 40) begin
      tick();
      c = c + 1;
      if (prev_b && !synchro_busy) begin
        seen = 1'b1;
        chk("single_arb_busy_held", 32'(arb_busy), 32'd1);
        tick();
        chk("single_arb_busy_fall", 32'(arb_busy), 32'd0);
      end
      prev_b = synchro_busy;
    end
    chk("single_busy_cycle_seen", 32'(seen), 32'd1);
    chk("single_count_pending", 32'({pulse_cnt - base, 28'(pending)}), 32'({32'd1, 28'd0}));

    // round robin over all four, then 0 and 2
    do_reset();
    model_en  = 1'b1;
    base      = pulse_cnt;
    req_pulse = 4'b1111;
    tick();
    req_pulse = '0;
    wait_drain("rr4", 4, base);
    chk("rr4_count", 32'(pulse_cnt - base), 32'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("rr4_id%0d", j), 32'(ids[base + j]), 32'(j));
    base      = pulse_cnt;
    req_pulse = 4'b0101;
    tick();
    req_pulse = '0;
    wait_drain("rr2", 2, base);
    chk("rr2_count", 32'(pulse_cnt - base), 32'd2);
    chk("rr2_first", 32'(ids[base]), 32'd0);
    chk("rr2_second", 32'(ids[base + 1]), 32'd2);

    // saturation while busy blocks arbitration
    do_reset();
    man_busy = 1'b1;
    tick();
    for (int j = 0; j < 9; j++) begin
      req_pulse = 4'b0010;
      tick();
    end
    req_pulse = '0;
    tick();
    chk("sat_pending", 32'(pending), 32'h2);
    chk("sat_overflow", 32'(overflow), 32'h2);
    chk("sat_no_pulse", 32'(arb_busy), 32'd0);
    base     = pulse_cnt;
    model_en = 1'b1;
    wait_drain("sat", 7, base);
    repeat (12) tick();
    chk("sat_count", 32'(pulse_cnt - base), 32'd7);
    c = 0;
    for (int j = 0; j < 7; j++) if (ids[base + j] != 1) c = c + 1;
    chk("sat_ids_all_one", 32'(c), 32'd0);
    chk("sat_overflow_sticky", 32'(overflow), 32'h2);
    ovf_clr = 4'b0010;
    tick();
    ovf_clr = '0;
    chk("sat_ovf_clr", 32'(overflow), 32'h0);

    // ack timeout with busy stuck low
    do_reset();
    base      = pulse_cnt;
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 1) chk("to_pulse", 32'(sync_pulse), 32'd1);
      if (j == 9) chk("to_before", 32'({timeout_err, arb_busy}), 32'b01);
      if (j == 10) chk("to_fire", 32'({timeout_err, arb_busy}), 32'b10);
    end
    repeat (20) tick();
    chk("to_no_reissue", 32'(pulse_cnt - base), 32'd1);
    chk("to_sticky", 32'({timeout_err, pending}), 32'({1'b1, 4'd0}));

    // busy already high in IDLE
    do_reset();
    man_busy  = 1'b1;
    base      = pulse_cnt;
    req_pulse = 4'b1000;
    tick();
    req_pulse = '0;
    repeat (6) tick();
    chk("bi_held", 32'({pulse_cnt - base, 28'(pending)}), 32'({32'd0, 28'h8}));
    man_busy = 1'b0;
    c = 0;
    while (pulse_cnt == base && c < 10) begin
      tick();
      c = c + 1;
    end
    chk("bi_issue", 32'({pulse_cnt - base, 28'(ids[base])}), 32'({32'd1, 28'd3}));

    // reset during WAIT_DONE with events queued
    do_reset();
    base      = pulse_cnt;
    req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    tick();
    man_busy = 1'b1;
    repeat (2) tick();
    req_pulse = 4'b0111;
    tick();
    req_pulse = '0;
    tick();
    chk("rm_queued", 32'({arb_busy, pending}), 32'({1'b1, 4'b0111}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_async_clear", 32'({sync_pulse, sync_id, pending, overflow, timeout_err, arb_busy}), 32'd0);
    tick();
    reset_n  = 1'b1;
    man_busy = 1'b0;
    base     = pulse_cnt;
    repeat (20) tick();
    chk("rm_no_transfer", 32'({pulse_cnt - base, 28'(pending)}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
